// File: rtl/regfile_pkg.sv
// +----------------------------------------------------------------------------+
// | regfile_pkg : shared constants, commit-source encoding and index helper     |
// | for the multi-port register file.                                           |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_AUX_REG  = 10;
  localparam int DEF_MEMD_REG = 11;
  localparam int DEF_MEMA_REG = 12;
  localparam int DEF_CTRL_REG = 13;
  localparam int DEF_CNT_W    = 8;

  // Which source updates reg[AUX_REG] in a given cycle.
  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_MAIN = 2'd1,
    WR_BUF  = 2'd2,
    WR_AUX  = 2'd3
  } wr_src_t;

  function automatic logic idx_ok(input int idx, input int num_regs);
    return (idx >= 0) && (idx < num_regs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_aux_hold_buf.sv
// +----------------------------------------------------------------------------+
// | aux_hold_buf : one-entry retry buffer for aux writes that lose arbitration  |
// | against the main port. Ready is a registered copy of "buffer empty".        |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module aux_hold_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [DATA_W-1:0] aux_data,
  input  logic              collision,
  output logic              xfer,
  output logic              drain,
  output logic              load,
  output logic [DATA_W-1:0] hold_data
);

  logic              r_full;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic              w_full_nxt;

  assign aux_ready = r_ready;
  assign hold_data = r_data;
  assign xfer      = aux_valid & r_ready;
  assign drain     = r_full & ~collision;
  assign load      = xfer & collision;

  always_comb begin
    w_full_nxt = r_full;
    if (load)
      w_full_nxt = 1'b1;
    else if (drain)
      w_full_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_data  <= '0;
    end else begin
      r_full  <= w_full_nxt;
      r_ready <= ~w_full_nxt;
      if (load)
        r_data <= aux_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// +----------------------------------------------------------------------------+
// | regfile_mp : parametrised register file, main + aux write ports, two read  |
// | ports and fixed taps. Optional macro REGFILE_BYPASS_EN forwards same-cycle  |
// | commits onto read ports A/B.                                                |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int AUX_REG  = DEF_AUX_REG,
  parameter int MEMD_REG = DEF_MEMD_REG,
  parameter int MEMA_REG = DEF_MEMA_REG,
  parameter int CTRL_REG = DEF_CTRL_REG,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_n,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       aux_valid,
  output logic                       aux_ready,
  input  logic [DATA_W-1:0]          aux_data,
  input  logic [ADDR_W-1:0]          rd_addr_a,
  output logic [DATA_W-1:0]          rd_data_a,
  input  logic [ADDR_W-1:0]          rd_addr_b,
  output logic [DATA_W-1:0]          rd_data_b,
  output logic [DATA_W-1:0]          ctrl,
  output logic [DATA_W-1:0]          mema_top,
  output logic [DATA_W-1:0]          memd_top,
  output logic [NUM_REGS*DATA_W-1:0] q,
  output logic [CNT_W-1:0]           coll_cnt
);

  localparam logic [ADDR_W-1:0] AUX_IDX   = ADDR_W'(AUX_REG);
  localparam logic [ADDR_W-1:0] MEMD_IDX  = ADDR_W'(MEMD_REG);
  localparam logic [ADDR_W-1:0] MEMA_IDX  = ADDR_W'(MEMA_REG);
  localparam logic [ADDR_W-1:0] CTRL_IDX  = ADDR_W'(CTRL_REG);
  localparam logic [ADDR_W:0]   NREGS_EXT = (ADDR_W+1)'(NUM_REGS);

  if (!idx_ok(AUX_REG, NUM_REGS) || !idx_ok(MEMD_REG, NUM_REGS) ||
      !idx_ok(MEMA_REG, NUM_REGS) || !idx_ok(CTRL_REG, NUM_REGS) ||
      AUX_REG == MEMD_REG || AUX_REG == MEMA_REG || AUX_REG == CTRL_REG ||
      MEMD_REG == MEMA_REG || MEMD_REG == CTRL_REG || MEMA_REG == CTRL_REG) begin : g_bad_idx
    $error("regfile_mp: fixed register indices must be distinct and < NUM_REGS");
  end

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [CNT_W-1:0]                r_coll_cnt;

  logic              main_we;
  logic              main_hit_aux;
  logic              aux_xfer;
  logic              buf_drain;
  logic              buf_load;
  logic [DATA_W-1:0] buf_data;
  wr_src_t           aux_src;

  assign main_we      = ~wr_en_n && ({1'b0, wr_addr} < NREGS_EXT);
  assign main_hit_aux = main_we && (wr_addr == AUX_IDX);

  aux_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_data  (aux_data),
    .collision (main_hit_aux),
    .xfer      (aux_xfer),
    .drain     (buf_drain),
    .load      (buf_load),
    .hold_data (buf_data)
  );

  // Buffer and new transfer are mutually exclusive since ready is low while full.
  always_comb begin
    aux_src = WR_NONE;
    if (main_hit_aux)
      aux_src = WR_MAIN;
    else if (buf_drain)
      aux_src = WR_BUF;
    else if (aux_xfer)
      aux_src = WR_AUX;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regs     <= '0;
      r_coll_cnt <= '0;
    end else begin
      if (main_we)
        r_regs[wr_addr] <= wr_data;
      if (aux_src == WR_BUF)
        r_regs[AUX_IDX] <= buf_data;
      else if (aux_src == WR_AUX)
        r_regs[AUX_IDX] <= aux_data;
      if (buf_load && (r_coll_cnt != '1))
        r_coll_cnt <= r_coll_cnt + 1'b1;
    end
  end

  always_comb begin
    rd_data_a = ({1'b0, rd_addr_a} < NREGS_EXT) ? r_regs[rd_addr_a] : '0;
    rd_data_b = ({1'b0, rd_addr_b} < NREGS_EXT) ? r_regs[rd_addr_b] : '0;
`ifdef REGFILE_BYPASS_EN
    if (main_we && (wr_addr == rd_addr_a))
      rd_data_a = wr_data;
    else if ((rd_addr_a == AUX_IDX) && (aux_src == WR_BUF))
      rd_data_a = buf_data;
    else if ((rd_addr_a == AUX_IDX) && (aux_src == WR_AUX))
      rd_data_a = aux_data;

    if (main_we && (wr_addr == rd_addr_b))
      rd_data_b = wr_data;
    else if ((rd_addr_b == AUX_IDX) && (aux_src == WR_BUF))
      rd_data_b = buf_data;
    else if ((rd_addr_b == AUX_IDX) && (aux_src == WR_AUX))
      rd_data_b = aux_data;
`endif
  end

  assign ctrl     = r_regs[CTRL_IDX];
  assign mema_top = r_regs[MEMA_IDX];
  assign memd_top = r_regs[MEMD_IDX];
  assign q        = r_regs;
  assign coll_cnt = r_coll_cnt;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// +----------------------------------------------------------------------------+
// | tb_regfile_mp : directed self-checking bench for regfile_mp (16x8 default). |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_mp;

  localparam int DW = 8;
  localparam int NR = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en_n;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          aux_valid;
  logic          aux_ready;
  logic [DW-1:0] aux_data;
  logic [AW-1:0] rd_addr_a;
  logic [DW-1:0] rd_data_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_b;
  logic [DW-1:0] ctrl;
  logic [DW-1:0] mema_top;
  logic [DW-1:0] memd_top;
  logic [NR*DW-1:0] q;
  logic [7:0]    coll_cnt;

  logic [NR*DW-1:0] exp_q;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_n   (wr_en_n),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_data  (aux_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .ctrl      (ctrl),
    .mema_top  (mema_top),
    .memd_top  (memd_top),
    .q         (q),
    .coll_cnt  (coll_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_n   = 1'b1;
    aux_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    wr_addr = '0; wr_data = '0; aux_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q = '0;
    n_checks++;
    if (q !== exp_q) begin
      n_fail++; $display("FAIL reset_q: got %h want %h", q, exp_q);
    end
    n_checks++;
    if (coll_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", coll_cnt);
    end
    n_checks++;
    if (aux_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", aux_ready);
    end
  endtask

  task automatic test_main_write();
    wr_en_n = 1'b0;
    wr_addr = 4'd3;  wr_data = 8'h5A; tick();
    wr_addr = 4'd13; wr_data = 8'hC1; tick();
    wr_addr = 4'd12; wr_data = 8'h07; tick();
    idle();
    exp_q[3*DW +: DW]  = 8'h5A;
    exp_q[13*DW +: DW] = 8'hC1;
    exp_q[12*DW +: DW] = 8'h07;
    rd_addr_a = 4'd3;
    rd_addr_b = 4'd12;
    #1;
    n_checks++;
    if (rd_data_a !== 8'h5A) begin
      n_fail++; $display("FAIL main_rd_a: got %h want 5a", rd_data_a);
    end
    n_checks++;
    if (rd_data_b !== 8'h07) begin
      n_fail++; $display("FAIL main_rd_b: got %h want 07", rd_data_b);
    end
    n_checks++;
    if (ctrl !== 8'hC1 || mema_top !== 8'h07 || memd_top !== 8'h00) begin
      n_fail++; $display("FAIL main_taps: got ctrl=%h mema=%h memd=%h want c1 07 00",
                         ctrl, mema_top, memd_top);
    end
    n_checks++;
    if (q !== exp_q) begin
      n_fail++; $display("FAIL main_q: got %h want %h", q, exp_q);
    end
  endtask

  task automatic test_aux_direct();
    logic [DW-1:0] vals [3];
    vals[0] = 8'h3F; vals[1] = 8'h40; vals[2] = 8'h41;
    for (int i = 0; i < 3; i++) begin
      aux_valid = 1'b1;
      aux_data  = vals[i];
      tick();
      exp_q[10*DW +: DW] = vals[i];
      n_checks++;
      if (q !== exp_q || aux_ready !== 1'b1) begin
        n_fail++; $display("FAIL aux_direct_%0d: got q=%h rdy=%b want q=%h rdy=1",
                           i, q, aux_ready, exp_q);
      end
    end
    idle();
    aux_data = 8'h3F;
    wr_en_n = 1'b0; wr_addr = 4'd10; wr_data = 8'h3F; tick();
    idle();
    exp_q[10*DW +: DW] = 8'h3F;
    n_checks++;
    if (coll_cnt !== 8'd0 || q !== exp_q) begin
      n_fail++; $display("FAIL aux_direct_cnt: got cnt=%0d q=%h want 0 %h", coll_cnt, q, exp_q);
    end
  endtask

  task automatic test_collision();
    wr_en_n = 1'b0; wr_addr = 4'd10; wr_data = 8'h11;
    aux_valid = 1'b1; aux_data = 8'h22;
    tick();
    idle();
    n_checks++;
    if (q[10*DW +: DW] !== 8'h11 || aux_ready !== 1'b0 || coll_cnt !== 8'd1) begin
      n_fail++; $display("FAIL coll_hold: got r10=%h rdy=%b cnt=%0d want 11 0 1",
                         q[10*DW +: DW], aux_ready, coll_cnt);
    end
    tick();
    n_checks++;
    if (q[10*DW +: DW] !== 8'h22 || aux_ready !== 1'b1 || coll_cnt !== 8'd1) begin
      n_fail++; $display("FAIL coll_drain: got r10=%h rdy=%b cnt=%0d want 22 1 1",
                         q[10*DW +: DW], aux_ready, coll_cnt);
    end
  endtask

  task automatic test_back_to_back();
    wr_en_n = 1'b0; wr_addr = 4'd10; wr_data = 8'h11;
    aux_valid = 1'b1; aux_data = 8'h22;
    tick();
    // Offered aux data while the buffer is full must be ignored.
    aux_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h30 + 8'(i);
      tick();
      n_checks++;
      if (q[10*DW +: DW] !== (8'h30 + 8'(i)) || aux_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle_%0d: got r10=%h rdy=%b want %h 0",
                           i, q[10*DW +: DW], aux_ready, 8'h30 + 8'(i));
      end
    end
    idle();
    tick();
    n_checks++;
    if (q[10*DW +: DW] !== 8'h22 || aux_ready !== 1'b1 || coll_cnt !== 8'd2) begin
      n_fail++; $display("FAIL hold_release: got r10=%h rdy=%b cnt=%0d want 22 1 2",
                         q[10*DW +: DW], aux_ready, coll_cnt);
    end
    tick();
    n_checks++;
    if (q[10*DW +: DW] !== 8'h22) begin
      n_fail++; $display("FAIL hold_no_extra: got r10=%h want 22", q[10*DW +: DW]);
    end
  endtask

  task automatic test_reset_drops_buffer();
    wr_en_n = 1'b0; wr_addr = 4'd10; wr_data = 8'h55;
    aux_valid = 1'b1; aux_data = 8'h66;
    tick();
    idle();
    n_checks++;
    if (aux_ready !== 1'b0 || coll_cnt !== 8'd3) begin
      n_fail++; $display("FAIL rstbuf_pre: got rdy=%b cnt=%0d want 0 3", aux_ready, coll_cnt);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q = '0;
    n_checks++;
    if (q !== exp_q || coll_cnt !== 8'd0 || aux_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstbuf_post: got q=%h cnt=%0d rdy=%b want 0 0 1",
                         q, coll_cnt, aux_ready);
    end
    tick();
    tick();
    n_checks++;
    if (q[10*DW +: DW] !== 8'h00) begin
      n_fail++; $display("FAIL rstbuf_dropped: got r10=%h want 00", q[10*DW +: DW]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_now;
`ifdef REGFILE_BYPASS_EN
    exp_now = 8'h9C;
`else
    exp_now = 8'h00;
`endif
    rd_addr_b = 4'd5;
    wr_en_n = 1'b0; wr_addr = 4'd5; wr_data = 8'h9C;
    #1;
    n_checks++;
    if (rd_data_b !== exp_now) begin
      n_fail++; $display("FAIL bypass_same: got %h want %h", rd_data_b, exp_now);
    end
    n_checks++;
    if (q[5*DW +: DW] !== 8'h00) begin
      n_fail++; $display("FAIL bypass_q: got %h want 00", q[5*DW +: DW]);
    end
    tick();
    idle();
    n_checks++;
    if (rd_data_b !== 8'h9C) begin
      n_fail++; $display("FAIL bypass_next: got %h want 9c", rd_data_b);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      wr_en_n = 1'b0; wr_addr = 4'd10; wr_data = 8'hA0;
      aux_valid = 1'b1; aux_data = 8'hB0;
      tick();
      idle();
      tick();
      if (i == 99) begin
        n_checks++;
        if (coll_cnt !== 8'd100) begin
          n_fail++; $display("FAIL sat_mid: got %0d want 100", coll_cnt);
        end
      end
    end
    n_checks++;
    if (coll_cnt !== 8'd255) begin
      n_fail++; $display("FAIL sat_final: got %0d want 255", coll_cnt);
    end
    n_checks++;
    if (q[10*DW +: DW] !== 8'hB0 || aux_ready !== 1'b1) begin
      n_fail++; $display("FAIL sat_state: got r10=%h rdy=%b want b0 1", q[10*DW +: DW], aux_ready);
    end
  endtask

  initial begin
    test_reset();
    test_main_write();
    test_aux_direct();
    test_collision();
    test_back_to_back();
    test_reset_drops_buffer();
    test_bypass();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
